reg_file_32x32: RTL and testbench

- General-purpose register file for the 32-bit single-cycle RISC datapath: 32 registers x 32 bits.
- Two asynchronous read ports, one synchronous write port.
- Read port B feeds the ALU-source 2:1 mux (I0 = rs2 data, I1 = immediate).
- Read port A feeds the ALU directly. The write port consumes the write-back mux output.

---
 rtl/reg_file_32x32.sv | 68 ++++++
 tb/tb_reg_file_32x32.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port, r0 hard-wired to zero.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_32x32 #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SP_IDX  = 2,
    parameter logic [31:0] SP_INIT = 32'h0000_0FFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;

    assign wr_en = we && (rd != '0);

    // Next-state: a single qualified write; r0 is never updated.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd] = wdata;
        end
        regs_d[0] = '0;
    end

    // Reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports; address 0 always returns zero regardless of storage or forwarding.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs1 != '0) begin
            rdata1 = regs_q[rs1];
        end
        if (rs2 != '0) begin
            rdata2 = regs_q[rs2];
        end
`ifdef REGFILE_BYPASS_EN
        if (!rst && wr_en && (rs1 == rd)) begin
            rdata1 = wdata;
        end
        if (!rst && wr_en && (rs2 == rd)) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: stimulus pushes model-predicted read data, a monitor pops and compares.
module tb_reg_file_32x32;

    localparam logic [31:0] SP_INIT = 32'h0000_0FFC;
    localparam int unsigned SP_IDX  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  a1;
        logic [4:0]  a2;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    bit          model_valid = 1'b0;
    int          total = 0;
    int          bad   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_32x32 dut (
        .clk    (clk),
        .rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .we     (we),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference read: what the architecture says a register read returns this cycle.
    function automatic logic [31:0] ref_read(input logic [4:0] s, input bit r, input bit w,
                                             input logic [4:0] a, input logic [31:0] d);
        if (s == 5'd0) return 32'h0;
        if (BYPASS && !r && w && a != 5'd0 && s == a) return d;
        return model[s];
    endfunction

    // Drive one cycle of inputs, record the expectation, then apply the edge's effect to the model.
    task automatic cycle(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input string tag);
        exp_t it;
        @(posedge clk);
        #2;
        rst = r; we = w; rd = a; wdata = d; rs1 = s1; rs2 = s2;
        if (model_valid) begin
            it.e1 = ref_read(s1, r, w, a, d);
            it.e2 = ref_read(s2, r, w, a, d);
            it.a1 = s1;
            it.a2 = s2;
            it.tag = tag;
            exp_q.push_back(it);
        end
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model[SP_IDX] = SP_INIT;
            model_valid = 1'b1;
        end else if (w && a != 5'd0) begin
            model[a] = d;
        end
    endtask

    // Monitor: combinational outputs are sampled mid-cycle, well away from the rising edge.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                total++;
                if (rdata1 !== it.e1) begin
                    bad++;
                    $display("FAIL %s rdata1 rs1=%0d got=%h required=%h", it.tag, it.a1, rdata1, it.e1);
                end
                total++;
                if (rdata2 !== it.e2) begin
                    bad++;
                    $display("FAIL %s rdata2 rs2=%0d got=%h required=%h", it.tag, it.a2, rdata2, it.e2);
                end
            end
        end
    end

    initial begin
        logic [4:0]  a, s1, s2;
        logic [31:0] d;
        bit          w, r;
        rst = 1'b0; we = 1'b0; rd = '0; wdata = '0; rs1 = '0; rs2 = '0;

        cycle(1, 0, 0, 0, 0, 0, "reset");
        cycle(0, 0, 0, 0, 2, 5, "reset_read");

        cycle(0, 1, 7, 32'hDEAD_BEEF, 0, 0, "write7");
        cycle(0, 0, 0, 0, 7, 7, "readback7");

        cycle(0, 1, 0, 32'hFFFF_FFFF, 0, 0, "write_r0");
        cycle(0, 0, 0, 0, 0, 0, "read_r0");

        cycle(0, 1, 9, 32'hAAAA_5555, 9, 9, "pre_rst9");
        cycle(1, 1, 9, 32'h1234_5678, 9, 2, "rst_vs_we");
        cycle(0, 0, 0, 0, 7, 9, "after_rst");

        cycle(0, 1, 4, 32'h11, 0, 0, "write4");
        cycle(0, 1, 4, 32'h22, 4, 4, "same_cycle_rw");
        cycle(0, 0, 0, 0, 4, 4, "after_rw");

        for (int i = 1; i < 32; i++) cycle(0, 1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 0, "b2b_write");
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), "sweep");

        // Random traffic, with reads biased toward the register being written.
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            w  = $urandom_range(0, 1) == 1;
            a  = 5'($urandom_range(0, 31));
            d  = w ? $urandom() : 32'hxxxx_xxxx;
            s1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            cycle(r, w, a, d, s1, s2, "random");
        end

        cycle(1, 0, 0, 0, 0, 0, "final_rst");
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(i), "final_sweep");

        @(posedge clk);
        #2;
        we = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending expectations got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
